// File: rtl/led_bar_counter.sv
// Key-driven thermometer bar counter: three active-low keys (clear/up/down),
// each synchronised and debounced, with optional auto-repeat on up/down.

module led_bar_key #(
    parameter int DEB = 4,
    parameter int RD  = 0,
    parameter int RP  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic ev
);
    localparam int DW = $clog2(DEB + 1);

    logic [1:0]    sync;
    logic [DW-1:0] deb_cnt;
    logic          flip, lvl_nxt, press, rep;

    assign flip    = (sync[1] != level) && (deb_cnt == DW'(DEB - 1));
    assign lvl_nxt = flip ? sync[1] : level;
    assign ev      = press | rep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            deb_cnt <= '0;
            level   <= 1'b1;
            press   <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            level <= lvl_nxt;
            press <= flip & ~sync[1];
            if (sync[1] == level || flip) deb_cnt <= '0;
            else                          deb_cnt <= deb_cnt + DW'(1);
        end
    end

    generate
        if (RD == 0) begin : g_norep
            assign rep = 1'b0;
        end else begin : g_rep
            localparam int HMAX = (RD > RP) ? RD : RP;
            localparam int HW   = $clog2(HMAX + 1);
            logic [HW-1:0] hold;
            // Counts down to the next repeat; zero means idle (key released).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold <= '0;
                    rep  <= 1'b0;
                end else if (lvl_nxt) begin
                    hold <= '0;
                    rep  <= 1'b0;
                end else if (flip) begin
                    hold <= HW'(RD);
                    rep  <= 1'b0;
                end else if (hold == HW'(1)) begin
                    hold <= HW'(RP);
                    rep  <= 1'b1;
                end else begin
                    if (hold != '0) hold <= hold - HW'(1);
                    rep <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

module led_bar_counter #(
    parameter int N_LEDS          = 8,
    parameter int STEP            = 2,
    parameter int SAT_MODE        = 0,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 10000000,
    localparam int CW             = $clog2(N_LEDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key1,
    input  logic              key2,
    input  logic              key3,
    output logic [CW-1:0]     count,
    output logic [N_LEDS-1:0] seq,
    output logic              limit
);
    localparam logic [CW:0]       NL   = (CW + 1)'(N_LEDS);
    localparam logic [CW:0]       ST   = (CW + 1)'(STEP);
    localparam logic [CW:0]       MOD  = (CW + 1)'(N_LEDS + 1);
    localparam logic [N_LEDS-1:0] ONES = '1;

    logic [2:0] key_in, lvl, ev;
    logic       up, dn, unused;
    logic [CW:0] cur, res;
    logic [CW-1:0] cnt_nxt;
    logic          lim_nxt;

    assign key_in = {key3, key2, key1};
    assign unused = ^lvl[2:1];

    for (genvar i = 0; i < 3; i++) begin : g_key
        led_bar_key #(
            .DEB(DEBOUNCE_CYCLES),
            .RD (i == 0 ? 0 : REPEAT_DELAY),
            .RP (REPEAT_PERIOD)
        ) u_key (
            .clk  (clk),
            .rst_n(rst_n),
            .key  (key_in[i]),
            .level(lvl[i]),
            .ev   (ev[i])
        );
    end

    // Steps are dropped while clear is held; opposing steps cancel.
    assign up = ev[1] & lvl[0] & ~ev[2];
    assign dn = ev[2] & lvl[0] & ~ev[1];

    always_comb begin
        cur     = {1'b0, count};
        res     = cur;
        lim_nxt = 1'b0;
        if (ev[0]) begin
            res = '0;
        end else if (up) begin
            res = cur + ST;
            if (res > NL) begin
                lim_nxt = 1'b1;
                res     = (SAT_MODE != 0) ? NL : res - MOD;
            end
        end else if (dn) begin
            if (cur < ST) begin
                lim_nxt = 1'b1;
                res     = (SAT_MODE != 0) ? '0 : cur + MOD - ST;
            end else begin
                res = cur - ST;
            end
        end
        cnt_nxt = res[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            seq   <= '0;
            limit <= 1'b0;
        end else begin
            count <= cnt_nxt;
            seq   <= ~(ONES >> cnt_nxt);
            limit <= lim_nxt;
        end
    end
endmodule

// File: doc/led_bar_counter.md
# led_bar_counter

Parametrised key-driven bar-graph counter: three active-low push keys clear, step up or step down a level counter that drives a thermometer-coded LED bar. Each key has its own synchroniser and debouncer. Up/down keys auto-repeat while held, and the counter either wraps or saturates. It sits between the board push keys and the LED bank and is the successor to the fixed 8-LED, step-2, undebounced counter.

## Interface
- N_LEDS, 8, number of LEDs in the bar; count range 0..N_LEDS; must be ≥2.
- STEP, 2, increment/decrement magnitude; must be 1..N_LEDS.
- SAT_MODE, 0, 0 = wrap modulo N_LEDS+1, 1 = saturate at 0 and N_LEDS.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a debounced level changes; must be ≥1.
- REPEAT_DELAY, 0, held cycles after a press event before the first auto-repeat; 0 disables auto-repeat.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeats; must be ≥1 when REPEAT_DELAY≠0.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- key1  in  1  clear key, active-low (0 = pressed).
- key2  in  1  up key, active-low.
- key3  in  1  down key, active-low.
- count  out  CW = clog2(N_LEDS+1)  current level.
- seq  out  N_LEDS  thermometer bar, MSB-first: the top `count` bits are 1 and the rest are 0.
- limit  out  1  one-cycle pulse when a step wrapped or was clamped.

## Operation
- Per key: 2-flop synchroniser, then debouncer. The debouncer counter increments each cycle the synchronised value differs from the debounced level and clears when they are equal. When the difference has persisted DEBOUNCE_CYCLES cycles, the debounced level flips on that edge.
- Press event: a registered one-cycle pulse on a debounced 1→0 transition. A release (0→1) produces no event.
- Auto-repeat (key2/key3 only, REPEAT_DELAY≠0):
  - A per-key hold counter starts at the press event.
  - While the debounced level stays 0, a repeat event fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles.
  - Release clears the hold counter immediately.
- Counter update, highest priority first:
  1. clear event: count←0 and limit stays 0.
  2. up event with debounced key1 = 1 and no simultaneous down event: count←count+STEP.
  3. down event with debounced key1 = 1 and no simultaneous up event: count←count−STEP.
  4. Otherwise hold.
- Up and down events in the same cycle cancel: no change, no limit.
- Up/down events while key1 is held (debounced 0) are discarded; they are not queued.
- Arithmetic is done at CW+1 bits.
  - Wrap mode: the result is reduced modulo N_LEDS+1, and limit pulses if the result crossed N_LEDS→0 or 0→N_LEDS.
  - Saturate mode: the result is clamped to [0, N_LEDS], and limit pulses if clamping changed the value. Limit also pulses if the count was already at the bound.
- seq is registered together with count (same edge), never decoded from a stale count.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - count = 0, seq = 0, limit = 0.
  - Synchroniser flops and debounced levels = 1 (released); debounce and hold counters = 0; event pulses = 0.
- Latency: if key goes low before edge E and stays low, the debounced level falls at edge E+1+DEBOUNCE_CYCLES, the press pulse is high for the following cycle, and count/seq/limit update at edge E+2+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES cycles at the synchroniser output produce no event.
- Auto-repeat events have the same one-cycle update latency as press events.
- Reset asserted mid-debounce or mid-repeat aborts everything. After release, a key still held low must debounce afresh and then generates one new press event.
- Throughput: at most one count change per cycle.

## Test plan
- Reset with all keys high → count=0, seq=8'b00000000, limit=0. Then press key2 for 10 cycles (N_LEDS=8, STEP=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=0) → count=2, seq=8'b11000000 exactly 6 edges after the first low sample.
- Key2 glitch low for 3 cycles, then key3 low for 3 cycles → no change in count, no limit pulse.
- Wrap mode: from count=7, key2 press → count=0 (9 mod 9), limit one cycle. Then key3 press from 1 → count=8, limit.
- Saturate mode: from count=7, key2 press → count=8, limit one cycle. A second key2 press → count stays 8, limit pulses again. Key1 press → count=0, no limit.
- Key1 held low, then key2 press → count unchanged. Release key1 → no deferred step. Key2 and key3 debounced-fall on the same edge → no change.
- REPEAT_DELAY=20, REPEAT_PERIOD=5, key2 held for 40 cycles after debounce → steps at the press event, +20, +25, +30, +35 (count 0→2→4→6→8→1 in wrap mode). Assert rst_n low mid-hold → count=0 immediately.
